// File: rtl/alu_reservation_station_pkg.sv
// Shared RISC-V definitions: datapath widths, ALU opcodes and the payload
// carried unchanged from issue to the ALU.
package riscv_defs;

    localparam int OP_W      = 4;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int DEF_TAG_W = 4;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [OP_W-1:0] OP_SLL  = 4'd5;
    localparam logic [OP_W-1:0] OP_SRL  = 4'd6;
    localparam logic [OP_W-1:0] OP_SRA  = 4'd7;
    localparam logic [OP_W-1:0] OP_SLT  = 4'd8;
    localparam logic [OP_W-1:0] OP_SLTU = 4'd9;
    localparam logic [OP_W-1:0] OP_BEQ  = 4'd10;
    localparam logic [OP_W-1:0] OP_BNE  = 4'd11;
    localparam logic [OP_W-1:0] OP_BLT  = 4'd12;
    localparam logic [OP_W-1:0] OP_BGE  = 4'd13;
    localparam logic [OP_W-1:0] OP_BLTU = 4'd14;
    localparam logic [OP_W-1:0] OP_BGEU = 4'd15;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] imm;
    } rs_payload_t;

endpackage

// File: rtl/alu_reservation_station_if.sv
// Issue, CDB and ALU-dispatch signals of the ALU reservation station.
// The station itself takes the slave side.
interface alu_reservation_station_if #(
    parameter int TAG_W = riscv_defs::DEF_TAG_W
);
    logic                          issue_valid;
    logic [riscv_defs::OP_W-1:0]   issue_op;
    logic [riscv_defs::DATA_W-1:0] issue_vj;
    logic [riscv_defs::DATA_W-1:0] issue_vk;
    logic [TAG_W-1:0]              issue_qj;
    logic [TAG_W-1:0]              issue_qk;
    logic                          issue_j_rdy;
    logic                          issue_k_rdy;
    logic [riscv_defs::ADDR_W-1:0] issue_pc;
    logic [riscv_defs::DATA_W-1:0] issue_imm;
    logic [TAG_W-1:0]              issue_tag;
    logic                          full;

    logic                          cdb_valid;
    logic [TAG_W-1:0]              cdb_tag;
    logic [riscv_defs::DATA_W-1:0] cdb_value;

    logic                          alu_valid;
    logic [riscv_defs::OP_W-1:0]   alu_op;
    logic [riscv_defs::DATA_W-1:0] alu_rs1;
    logic [riscv_defs::DATA_W-1:0] alu_rs2;
    logic [riscv_defs::ADDR_W-1:0] alu_pc;
    logic [riscv_defs::DATA_W-1:0] alu_imm;
    logic [TAG_W-1:0]              alu_tag;

    modport master (
        output issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
        output issue_j_rdy, issue_k_rdy, issue_pc, issue_imm, issue_tag,
        output cdb_valid, cdb_tag, cdb_value,
        input  full,
        input  alu_valid, alu_op, alu_rs1, alu_rs2, alu_pc, alu_imm, alu_tag
    );

    modport slave (
        input  issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
        input  issue_j_rdy, issue_k_rdy, issue_pc, issue_imm, issue_tag,
        input  cdb_valid, cdb_tag, cdb_value,
        output full,
        output alu_valid, alu_op, alu_rs1, alu_rs2, alu_pc, alu_imm, alu_tag
    );

endinterface

// File: rtl/rs_priority_enc.sv
// Lowest-index set-bit encoder: found flags any set bit, index is the lowest one.
module rs_priority_enc #(
    parameter  int WIDTH = 8,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    always_comb begin
        found = |req;
        index = '0;
        // Walk downward so the lowest set bit is the last one written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds issued instructions until both operands are
// known (snooping the CDB), then dispatches the lowest-index ready entry.
module alu_reservation_station
    import riscv_defs::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = DEF_TAG_W
) (
    input logic                        clk_in,
    input logic                        rst_in,
    input logic                        rdy_in,
    input logic                        flush_in,
    alu_reservation_station_if.slave   bus
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic              busy;
        logic              j_rdy;
        logic              k_rdy;
        logic [TAG_W-1:0]  qj;
        logic [TAG_W-1:0]  qk;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        rs_payload_t       pl;
    } entry_t;

    entry_t ent_q [DEPTH];
    entry_t ent_d [DEPTH];
    entry_t new_ent;

    logic [DEPTH-1:0] busy_vec;
    logic [DEPTH-1:0] ready_vec;
    logic             free_found;
    logic             disp_found;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] disp_idx;
    logic             full;
    logic             issue_ok;
    logic             bypass_j;
    logic             bypass_k;

    logic              alu_valid_q, alu_valid_d;
    rs_payload_t       alu_pl_q, alu_pl_d;
    logic [DATA_W-1:0] alu_rs1_q, alu_rs1_d;
    logic [DATA_W-1:0] alu_rs2_q, alu_rs2_d;
    logic [TAG_W-1:0]  alu_tag_q, alu_tag_d;

    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_vec[i]  = ent_q[i].busy;
            ready_vec[i] = ent_q[i].busy && ent_q[i].j_rdy && ent_q[i].k_rdy;
        end
    end

    rs_priority_enc #(
        .WIDTH (DEPTH)
    ) u_free_enc (
        .req   (~busy_vec),
        .found (free_found),
        .index (free_idx)
    );

    rs_priority_enc #(
        .WIDTH (DEPTH)
    ) u_disp_enc (
        .req   (ready_vec),
        .found (disp_found),
        .index (disp_idx)
    );

    // Registered-state only: a same-cycle dispatch does not open a slot.
    assign full     = &busy_vec;
    assign issue_ok = bus.issue_valid && !full && free_found;

    // Incoming entry, with same-cycle CDB bypass for operands still pending.
    always_comb begin
        bypass_j = bus.cdb_valid && !bus.issue_j_rdy && (bus.cdb_tag == bus.issue_qj);
        bypass_k = bus.cdb_valid && !bus.issue_k_rdy && (bus.cdb_tag == bus.issue_qk);

        new_ent        = '0;
        new_ent.busy   = TRUE;
        new_ent.pl.op  = bus.issue_op;
        new_ent.pl.pc  = bus.issue_pc;
        new_ent.pl.imm = bus.issue_imm;
        new_ent.tag    = bus.issue_tag;
        new_ent.qj     = bus.issue_qj;
        new_ent.qk     = bus.issue_qk;
        new_ent.j_rdy  = bus.issue_j_rdy || bypass_j;
        new_ent.k_rdy  = bus.issue_k_rdy || bypass_k;
        new_ent.vj     = bypass_j ? bus.cdb_value : bus.issue_vj;
        new_ent.vk     = bypass_k ? bus.cdb_value : bus.issue_vk;
    end

    always_comb begin
        ent_d       = ent_q;
        alu_valid_d = alu_valid_q;
        alu_pl_d    = alu_pl_q;
        alu_rs1_d   = alu_rs1_q;
        alu_rs2_d   = alu_rs2_q;
        alu_tag_d   = alu_tag_q;

        if (flush_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].busy = FALSE;
            end
            alu_valid_d = FALSE;
        end else begin
            if (bus.cdb_valid) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (ent_q[i].busy && !ent_q[i].j_rdy && ent_q[i].qj == bus.cdb_tag) begin
                        ent_d[i].vj    = bus.cdb_value;
                        ent_d[i].j_rdy = TRUE;
                    end
                    if (ent_q[i].busy && !ent_q[i].k_rdy && ent_q[i].qk == bus.cdb_tag) begin
                        ent_d[i].vk    = bus.cdb_value;
                        ent_d[i].k_rdy = TRUE;
                    end
                end
            end

            alu_valid_d = disp_found;
            if (disp_found) begin
                alu_pl_d             = ent_q[disp_idx].pl;
                alu_rs1_d            = ent_q[disp_idx].vj;
                alu_rs2_d            = ent_q[disp_idx].vk;
                alu_tag_d            = ent_q[disp_idx].tag;
                ent_d[disp_idx].busy = FALSE;
            end

            // free_idx comes from registered busy, so it never hits the dispatched slot.
            if (issue_ok) begin
                ent_d[free_idx] = new_ent;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            alu_valid_q <= FALSE;
            alu_pl_q    <= '0;
            alu_rs1_q   <= '0;
            alu_rs2_q   <= '0;
            alu_tag_q   <= '0;
        end else if (rdy_in) begin
            ent_q       <= ent_d;
            alu_valid_q <= alu_valid_d;
            alu_pl_q    <= alu_pl_d;
            alu_rs1_q   <= alu_rs1_d;
            alu_rs2_q   <= alu_rs2_d;
            alu_tag_q   <= alu_tag_d;
        end
    end

    assign bus.full      = full;
    assign bus.alu_valid = alu_valid_q;
    assign bus.alu_op    = alu_pl_q.op;
    assign bus.alu_pc    = alu_pl_q.pc;
    assign bus.alu_imm   = alu_pl_q.imm;
    assign bus.alu_rs1   = alu_rs1_q;
    assign bus.alu_rs2   = alu_rs2_q;
    assign bus.alu_tag   = alu_tag_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench for alu_reservation_station: directed scenarios plus a
// randomized run against a cycle-level reference model of the station.
module tb_alu_reservation_station;
    import riscv_defs::*;

    localparam int DEPTH = 8;
    localparam int TAG_W = 4;

    logic clk_in   = 1'b0;
    logic rst_in   = 1'b0;
    logic rdy_in   = 1'b1;
    logic flush_in = 1'b0;

    int checks = 0;
    int errors = 0;

    alu_reservation_station_if #(.TAG_W(TAG_W)) bus();

    alu_reservation_station #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .flush_in (flush_in),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: waiting operand stored as producer tag, -1 when known.
    bit          m_busy [DEPTH];
    int          m_wj   [DEPTH];
    int          m_wk   [DEPTH];
    logic [31:0] m_vj   [DEPTH];
    logic [31:0] m_vk   [DEPTH];
    logic [31:0] m_pc   [DEPTH];
    logic [31:0] m_imm  [DEPTH];
    logic [3:0]  m_op   [DEPTH];
    logic [3:0]  m_tag  [DEPTH];
    bit          m_av;
    logic [3:0]  m_aop, m_atag;
    logic [31:0] m_rs1, m_rs2, m_apc, m_aimm;

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
        m_av = 0; m_aop = 0; m_atag = 0; m_rs1 = 0; m_rs2 = 0; m_apc = 0; m_aimm = 0;
    endtask

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += m_busy[i] ? 1 : 0;
        return n;
    endfunction

    function automatic bit m_full();
        return m_count() == DEPTH;
    endfunction

    task automatic model_step();
        int d = -1;
        int f = -1;
        int occupied;
        if (!rdy_in) return;
        if (flush_in) begin
            for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
            m_av = 0;
            return;
        end
        occupied = m_count();
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (m_busy[i] && m_wj[i] < 0 && m_wk[i] < 0) d = i;
            if (!m_busy[i]) f = i;
        end
        if (bus.cdb_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (m_busy[i] && m_wj[i] == int'(bus.cdb_tag)) begin
                    m_vj[i] = bus.cdb_value; m_wj[i] = -1;
                end
                if (m_busy[i] && m_wk[i] == int'(bus.cdb_tag)) begin
                    m_vk[i] = bus.cdb_value; m_wk[i] = -1;
                end
            end
        end
        m_av = (d >= 0);
        if (d >= 0) begin
            m_aop = m_op[d]; m_rs1 = m_vj[d]; m_rs2 = m_vk[d];
            m_apc = m_pc[d]; m_aimm = m_imm[d]; m_atag = m_tag[d];
            m_busy[d] = 0;
        end
        if (bus.issue_valid && occupied < DEPTH) begin
            m_busy[f] = 1;
            m_op[f] = bus.issue_op; m_pc[f] = bus.issue_pc; m_imm[f] = bus.issue_imm;
            m_tag[f] = bus.issue_tag;
            m_vj[f] = bus.issue_vj; m_vk[f] = bus.issue_vk;
            m_wj[f] = bus.issue_j_rdy ? -1 : int'(bus.issue_qj);
            m_wk[f] = bus.issue_k_rdy ? -1 : int'(bus.issue_qk);
            if (bus.cdb_valid && m_wj[f] == int'(bus.cdb_tag)) begin
                m_vj[f] = bus.cdb_value; m_wj[f] = -1;
            end
            if (bus.cdb_valid && m_wk[f] == int'(bus.cdb_tag)) begin
                m_vk[f] = bus.cdb_value; m_wk[f] = -1;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_idle();
        bus.issue_valid = 0; bus.issue_op = '0; bus.issue_vj = '0; bus.issue_vk = '0;
        bus.issue_qj = '0; bus.issue_qk = '0; bus.issue_j_rdy = 0; bus.issue_k_rdy = 0;
        bus.issue_pc = '0; bus.issue_imm = '0; bus.issue_tag = '0;
        bus.cdb_valid = 0; bus.cdb_tag = '0; bus.cdb_value = '0;
        flush_in = 0; rdy_in = 1;
    endtask

    task automatic drive_issue(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                               input int qj, input int qk, input bit jr, input bit kr,
                               input int tag);
        bus.issue_valid = 1; bus.issue_op = op; bus.issue_vj = vj; bus.issue_vk = vk;
        bus.issue_qj = 4'(qj); bus.issue_qk = 4'(qk);
        bus.issue_j_rdy = jr; bus.issue_k_rdy = kr;
        bus.issue_pc = $urandom; bus.issue_imm = $urandom; bus.issue_tag = 4'(tag);
    endtask

    task automatic test_reset();
        drive_idle();
        m_reset();
        rst_in = 0;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1;
        checks++; if (bus.alu_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", bus.alu_valid); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", bus.full); end
        checks++; if ({bus.alu_rs1, bus.alu_rs2, bus.alu_tag} !== '0) begin errors++; $display("FAIL reset_data got %h/%h/%h exp 0", bus.alu_rs1, bus.alu_rs2, bus.alu_tag); end
    endtask

    task automatic test_ready_issue();
        drive_issue(OP_ADD, 32'd5, 32'd7, 0, 0, 1, 1, 3);
        tick();
        drive_idle();
        checks++; if (bus.alu_valid !== 1'b0) begin errors++; $display("FAIL ready_early got %0b exp 0", bus.alu_valid); end
        tick();
        checks++; if (bus.alu_valid !== 1'b1) begin errors++; $display("FAIL ready_valid got %0b exp 1", bus.alu_valid); end
        checks++; if ({bus.alu_op, bus.alu_rs1, bus.alu_rs2, bus.alu_tag} !== {OP_ADD, 32'd5, 32'd7, 4'd3}) begin
            errors++; $display("FAIL ready_fields got op %0d rs1 %0d rs2 %0d tag %0d exp 0/5/7/3", bus.alu_op, bus.alu_rs1, bus.alu_rs2, bus.alu_tag);
        end
        tick();
        checks++; if (bus.alu_valid !== 1'b0) begin errors++; $display("FAIL ready_once got %0b exp 0", bus.alu_valid); end
    endtask

    task automatic test_cdb_wakeup();
        drive_issue(OP_SUB, 32'hDEAD, 32'd1, 9, 0, 0, 1, 4);
        tick();
        drive_idle();
        tick();
        checks++; if (bus.alu_valid !== 1'b0) begin errors++; $display("FAIL wake_wait got %0b exp 0", bus.alu_valid); end
        bus.cdb_valid = 1; bus.cdb_tag = 4'd9; bus.cdb_value = 32'h10;
        tick();
        drive_idle();
        checks++; if (bus.alu_valid !== 1'b0) begin errors++; $display("FAIL wake_early got %0b exp 0", bus.alu_valid); end
        tick();
        checks++; if ({bus.alu_valid, bus.alu_op, bus.alu_rs1, bus.alu_rs2, bus.alu_tag} !== {1'b1, OP_SUB, 32'h10, 32'd1, 4'd4}) begin
            errors++; $display("FAIL wake_dispatch got v %0b rs1 %h rs2 %h tag %0d exp 1/10/1/4", bus.alu_valid, bus.alu_rs1, bus.alu_rs2, bus.alu_tag);
        end
        tick();
        drive_issue(OP_SUB, 32'hBEEF, 32'd2, 9, 0, 0, 1, 5);
        bus.cdb_valid = 1; bus.cdb_tag = 4'd9; bus.cdb_value = 32'h22;
        tick();
        drive_idle();
        checks++; if (bus.alu_valid !== 1'b0) begin errors++; $display("FAIL bypass_early got %0b exp 0", bus.alu_valid); end
        tick();
        checks++; if ({bus.alu_valid, bus.alu_rs1, bus.alu_tag} !== {1'b1, 32'h22, 4'd5}) begin
            errors++; $display("FAIL bypass_dispatch got v %0b rs1 %h tag %0d exp 1/22/5", bus.alu_valid, bus.alu_rs1, bus.alu_tag);
        end
        tick();
    endtask

    task automatic test_fill_and_stall();
        for (int i = 0; i < DEPTH; i++) begin
            drive_issue(OP_ADD, 32'd0, 32'(100 + i), 15, 0, 0, 1, i);
            tick();
        end
        drive_idle();
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full got %0b exp 1", bus.full); end
        drive_issue(OP_OR, 32'd1, 32'd2, 0, 0, 1, 1, 9);
        tick();
        drive_idle();
        checks++; if ({bus.full, bus.alu_valid} !== 2'b10) begin errors++; $display("FAIL fill_drop got full %0b valid %0b exp 1/0", bus.full, bus.alu_valid); end
        bus.cdb_valid = 1; bus.cdb_tag = 4'd15; bus.cdb_value = 32'h55;
        tick();
        drive_idle();
        checks++; if ({bus.full, bus.alu_valid} !== 2'b10) begin errors++; $display("FAIL fill_snoop got full %0b valid %0b exp 1/0", bus.full, bus.alu_valid); end
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            checks++; if ({bus.alu_valid, bus.alu_tag, bus.alu_rs1, bus.alu_rs2} !== {1'b1, 4'(i), 32'h55, 32'(100 + i)}) begin
                errors++; $display("FAIL fill_order%0d got v %0b tag %0d rs2 %0d exp 1/%0d/%0d", i, bus.alu_valid, bus.alu_tag, bus.alu_rs2, i, 100 + i);
            end
            if (i == 0) begin
                checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL fill_release got %0b exp 0", bus.full); end
            end
        end
        tick();
        checks++; if (bus.alu_valid !== 1'b0) begin errors++; $display("FAIL fill_ninth got %0b exp 0", bus.alu_valid); end
    endtask

    task automatic test_flush();
        for (int i = 1; i <= 3; i++) begin
            drive_issue(OP_XOR, 32'd0, 32'd0, 12, 0, 0, 1, i);
            tick();
        end
        drive_issue(OP_AND, 32'd3, 32'd4, 0, 0, 1, 1, 4);
        tick();
        drive_idle();
        flush_in = 1;
        tick();
        drive_idle();
        checks++; if ({bus.alu_valid, bus.full} !== 2'b00) begin errors++; $display("FAIL flush_clear got valid %0b full %0b exp 0/0", bus.alu_valid, bus.full); end
        bus.cdb_valid = 1; bus.cdb_tag = 4'd12; bus.cdb_value = 32'h99;
        for (int i = 0; i < 3; i++) begin
            tick();
            drive_idle();
            checks++; if (bus.alu_valid !== 1'b0) begin errors++; $display("FAIL flush_stale%0d got %0b exp 0", i, bus.alu_valid); end
        end
    endtask

    task automatic test_stall();
        drive_issue(OP_ADD, 32'hA1, 32'hA2, 0, 0, 1, 1, 5);
        tick();
        drive_issue(OP_ADD, 32'hB1, 32'hB2, 0, 0, 1, 1, 6);
        tick();
        drive_idle();
        checks++; if ({bus.alu_valid, bus.alu_tag, bus.alu_rs1} !== {1'b1, 4'd5, 32'hA1}) begin
            errors++; $display("FAIL stall_pre got v %0b tag %0d rs1 %h exp 1/5/a1", bus.alu_valid, bus.alu_tag, bus.alu_rs1);
        end
        for (int i = 0; i < 3; i++) begin
            rdy_in = 0;
            drive_issue(OP_SUB, 32'd1, 32'd1, 0, 0, 1, 1, 9);
            bus.cdb_valid = 1; bus.cdb_tag = 4'd7; bus.cdb_value = 32'h77;
            tick();
            checks++; if ({bus.alu_valid, bus.alu_tag, bus.alu_rs1, bus.alu_rs2} !== {1'b1, 4'd5, 32'hA1, 32'hA2}) begin
                errors++; $display("FAIL stall_hold%0d got v %0b tag %0d rs1 %h exp 1/5/a1", i, bus.alu_valid, bus.alu_tag, bus.alu_rs1);
            end
        end
        drive_idle();
        tick();
        checks++; if ({bus.alu_valid, bus.alu_tag, bus.alu_rs1} !== {1'b1, 4'd6, 32'hB1}) begin
            errors++; $display("FAIL stall_resume got v %0b tag %0d rs1 %h exp 1/6/b1", bus.alu_valid, bus.alu_tag, bus.alu_rs1);
        end
        tick();
        checks++; if (bus.alu_valid !== 1'b0) begin errors++; $display("FAIL stall_ignored got %0b exp 0", bus.alu_valid); end
    endtask

    task automatic test_async_reset();
        drive_issue(OP_ADD, 32'h77, 32'h1, 0, 0, 1, 1, 7);
        tick();
        drive_issue(OP_ADD, 32'h0, 32'h0, 13, 0, 0, 1, 8);
        tick();
        drive_idle();
        checks++; if (bus.alu_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got %0b exp 1", bus.alu_valid); end
        #2 rst_in = 0;
        m_reset();
        #1;
        checks++; if ({bus.alu_valid, bus.full} !== 2'b00) begin errors++; $display("FAIL areset_now got valid %0b full %0b exp 0/0", bus.alu_valid, bus.full); end
        checks++; if ({bus.alu_rs1, bus.alu_tag} !== '0) begin errors++; $display("FAIL areset_data got rs1 %h tag %0d exp 0", bus.alu_rs1, bus.alu_tag); end
        @(negedge clk_in);
        rst_in = 1;
        @(posedge clk_in);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL areset_free%0d got full %0b exp 0", i, bus.full); end
            drive_issue(OP_ADD, 32'd0, 32'd0, 14, 0, 0, 1, i);
            tick();
        end
        drive_idle();
        checks++; if ({bus.full, bus.alu_valid} !== 2'b10) begin errors++; $display("FAIL areset_refill got full %0b valid %0b exp 1/0", bus.full, bus.alu_valid); end
        flush_in = 1;
        tick();
        drive_idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive_idle();
            rdy_in   = ($urandom_range(9) != 0);
            flush_in = ($urandom_range(39) == 0);
            bus.cdb_valid = $urandom_range(1); bus.cdb_tag = 4'($urandom_range(7));
            bus.cdb_value = $urandom;
            if ($urandom_range(1) == 1 && !m_full()) begin
                drive_issue(4'($urandom_range(15)), $urandom, $urandom, $urandom_range(7),
                            $urandom_range(7), $urandom_range(1), $urandom_range(1),
                            $urandom_range(15));
            end
            tick();
            checks++; if (bus.alu_valid !== m_av || bus.full !== m_full()) begin
                errors++; $display("FAIL rand%0d_ctl got valid %0b full %0b exp %0b/%0b", c, bus.alu_valid, bus.full, m_av, m_full());
            end
            if (m_av) begin
                checks++; if ({bus.alu_op, bus.alu_rs1, bus.alu_rs2, bus.alu_pc, bus.alu_imm, bus.alu_tag} !== {m_aop, m_rs1, m_rs2, m_apc, m_aimm, m_atag}) begin
                    errors++; $display("FAIL rand%0d_data got tag %0d rs1 %h rs2 %h exp tag %0d rs1 %h rs2 %h", c, bus.alu_tag, bus.alu_rs1, bus.alu_rs2, m_atag, m_rs1, m_rs2);
                end
            end
        end
        drive_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_ready_issue();
        test_cdb_wakeup();
        test_fill_and_stall();
        test_flush();
        test_stall();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
